fp_add_rr_arbiter: RTL
======================

// Module: fp_add_rr_arbiter
// PURPOSE
//  Shares one pipelined FP32 adder between N requesters. Round-robin grant per cycle, registered issue
//  into the adder. Tracks each issued op's owner in a tag pipeline matched to adder latency and returns
//  the sum with owner ID. FSM supports flush/drain so the adder can be quiesced before reconfiguration.
// PARAMETERS
//  N_REQ        4    number of requesters (>=1)
//  ADD_LATENCY  4    cycles from add_vld_o to matching add_answer_i/add_status_i (>=1)
//  CNT_W        16   width of per-requester grant counters (FP_ARB_STATS_EN only)
// PORTS
//  clk_i         in   1             clock
//  rst_i         in   1             synchronous reset, active-high
//  req_vld_i     in   N_REQ         requester has an operand pair
//  req_a_i       in   N_REQ x 32    operand A, IEEE-754 single
//  req_b_i       in   N_REQ x 32    operand B
//  req_rdy_o     out  N_REQ         one-hot grant; transfer when vld&rdy
//  flush_i       in   1             level: stop granting, drain pipeline
//  idle_o        out  1             no op in flight and FSM in IDLE
//  add_vld_o     out  1             issue strobe to adder
//  add_a_o       out  32            operand A to adder
//  add_b_o       out  32            operand B to adder
//  add_answer_i  in   32            adder result
//  add_status_i  in   2             adder num_status
//  rsp_vld_o     out  1             result valid (no backpressure, one cycle)
//  rsp_id_o      out  ID_W          owner index, ID_W = max(1,$clog2(N_REQ))
//  rsp_data_o    out  32            = add_answer_i when rsp_vld_o
//  rsp_status_o  out  2             = add_status_i when rsp_vld_o
// BEHAVIOUR
//  - Reset: all outputs 0 (add_*, rsp_*, req_rdy_o), idle_o=1, FSM=IDLE, rr pointer=0, tag pipe cleared.
//  - FSM IDLE->RUN on any req_vld_i & !flush_i; RUN->DRAIN on flush_i; RUN->IDLE when no req_vld_i and
//    in-flight=0; DRAIN->IDLE when in-flight=0 and !flush_i; in DRAIN with flush_i held, stays DRAIN/IDLE.
//  - req_rdy_o combinational: in IDLE/RUN with !flush_i, exactly one bit set = first req_vld_i at or after
//    rr pointer (wrap N_REQ-1 -> 0); all zero in DRAIN or when flush_i=1. Max one accept per cycle.
//  - On accept of requester k: next cycle add_vld_o=1, add_a_o/add_b_o = req_a_i[k]/req_b_i[k];
//    pointer <= (k+1) mod N_REQ. No accept -> add_vld_o=0, add_a_o/add_b_o hold.
//  - Tag pipe: ADD_LATENCY stages of {vld,id}, free-running shift, loaded from add_vld_o/issued id.
//    Stage-out valid -> rsp_vld_o=1 same cycle, rsp_id_o=id, rsp_data_o/rsp_status_o from adder inputs.
//    Accept-to-response latency = 1 + ADD_LATENCY cycles; throughput 1 op/cycle, back-to-back legal.
//  - rsp_data_o/rsp_status_o/rsp_id_o are 0 when rsp_vld_o=0.
//  - In-flight counter 0..ADD_LATENCY+1: +1 on accept, -1 on rsp_vld_o, both -> unchanged.
//    idle_o = (FSM==IDLE) && count==0.
//  - flush_i asserted same cycle as req_vld_i: no accept. Ops already issued complete normally.
//  - rst_i mid-operation: tag pipe cleared, in-flight results discarded (rsp_vld_o stays 0 even if
//    adder output changes).
//  - N_REQ=1: rr pointer constant 0, rsp_id_o always 0.
// CONFIGURATION
//  FP_ARB_STATS_EN defined: adds output grant_cnt_o [N_REQ x CNT_W]; per-requester count of accepts,
//    saturating at all-ones, cleared by rst_i only.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  float_types_pkg: add FP_ADD_LATENCY constant (=4) and arb_state_e {IDLE,RUN,DRAIN}; reuse
//    float_point_num and existing num_status encodings.
//  One sub-module: rr_grant_picker (N_REQ, req vector + pointer -> one-hot grant + index, combinational).
//    Tag pipe is local always_ff, not shift_reg (that module's enable gating does not fit here).
// TESTING
//  1 req0: a=0x3F800000 b=0x40000000 -> rsp at accept+5: id=0, data=0x40400000.
//  2 all 4 requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp ids same order, no bubbles.
//  3 req2 only, pointer at 3 -> wrap selects 2; next grant search starts at 3.
//  4 flush_i during stream -> req_rdy_o=0 next edge, in-flight rsps still arrive, idle_o=1 after last
//    rsp with flush_i low.
//  5 rst_i 2 cycles after 3 accepts -> no rsp_vld_o afterwards, idle_o=1, pointer=0.
//  6 FP_ARB_STATS_EN: 10 accepts from req1, CNT_W=3 -> grant_cnt_o[1]=7 (saturated), others 0.

Source files
------------

// File: rtl/fp_add_rr_arbiter_pkg.sv
// Shared types for the FP32 adder round-robin arbiter: adder latency, operand/status types,
// arbiter FSM states and the round-robin index helper.
package fp_add_rr_arbiter_pkg;

  localparam int FP_ADD_LATENCY = 4;

  typedef logic [31:0] float_point_num;
  typedef logic [1:0]  num_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/fp_add_rr_arbiter_rr_grant_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i (wrapping) wins,
// producing a one-hot grant, its index and an any-grant flag.
module rr_grant_picker
  import fp_add_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_o && req_i[rr_wrap(int'(ptr_i), i, N_REQ)]) begin
        any_o = 1'b1;
        gnt_o[rr_wrap(int'(ptr_i), i, N_REQ)] = 1'b1;
        idx_o = ID_W'(rr_wrap(int'(ptr_i), i, N_REQ));
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/fp_add_rr_arbiter.sv
// Shares one pipelined FP32 adder between N_REQ requesters with round-robin issue, owner tag
// pipe and flush/drain FSM. Optional grant counters when FP_ARB_STATS_EN is defined.
module fp_add_rr_arbiter
  import fp_add_rr_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADD_LATENCY = FP_ADD_LATENCY,
`ifdef FP_ARB_STATS_EN
  parameter int CNT_W       = 16,
`endif
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_vld_i,
  input  logic [N_REQ*32-1:0]   req_a_i,
  input  logic [N_REQ*32-1:0]   req_b_i,
  output logic [N_REQ-1:0]      req_rdy_o,
  input  logic                  flush_i,
  output logic                  idle_o,
  output logic                  add_vld_o,
  output logic [31:0]           add_a_o,
  output logic [31:0]           add_b_o,
  input  logic [31:0]           add_answer_i,
  input  logic [1:0]            add_status_i,
`ifdef FP_ARB_STATS_EN
  output logic [N_REQ*CNT_W-1:0] grant_cnt_o,
`endif
  output logic                  rsp_vld_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [31:0]           rsp_data_o,
  output logic [1:0]            rsp_status_o
);

  localparam int CW = $clog2(ADD_LATENCY + 2);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, iss_id_q, gnt_idx_s;
  logic [N_REQ-1:0]    gnt_s;
  logic                gnt_any_s, grant_en_s;
  logic                add_vld_q;
  float_point_num      add_a_q, add_b_q, sel_a_s, sel_b_s;
  logic [ADD_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]     tag_id_q [ADD_LATENCY];
  logic [CW-1:0]       cnt_q, cnt_d;

  // Reset also blocks grants so nothing is accepted during the reset cycle.
  assign grant_en_s = !rst_i && !flush_i && (state_q != DRAIN);

  rr_grant_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i (req_vld_i & {N_REQ{grant_en_s}}),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (gnt_any_s)
  );

  assign req_rdy_o = gnt_s;

  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_s[k]) begin
        sel_a_s = req_a_i[k*32 +: 32];
        sel_b_s = req_b_i[k*32 +: 32];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      add_vld_q <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      iss_id_q  <= '0;
      ptr_q     <= '0;
    end else begin
      add_vld_q <= gnt_any_s;
      if (gnt_any_s) begin
        add_a_q  <= sel_a_s;
        add_b_q  <= sel_b_s;
        iss_id_q <= gnt_idx_s;
        ptr_q    <= (gnt_idx_s == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
      end
    end
  end

  assign add_vld_o = add_vld_q;
  assign add_a_o   = add_a_q;
  assign add_b_o   = add_b_q;

  // Owner tags ride alongside the adder so the last stage lines up with add_answer_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_q <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= add_vld_q;
      tag_id_q[0]  <= iss_id_q;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign rsp_vld_o    = tag_vld_q[ADD_LATENCY-1];
  assign rsp_id_o     = rsp_vld_o ? tag_id_q[ADD_LATENCY-1] : '0;
  assign rsp_data_o   = rsp_vld_o ? add_answer_i : 32'h0000_0000;
  assign rsp_status_o = rsp_vld_o ? add_status_i : 2'b00;

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt_any_s, rsp_vld_o})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((|req_vld_i) && !flush_i) state_d = RUN;
               else state_d = IDLE;
      RUN:     if (flush_i) state_d = DRAIN;
               else if (!(|req_vld_i) && (cnt_q == '0)) state_d = IDLE;
               else state_d = RUN;
      DRAIN:   if ((cnt_q == '0) && !flush_i) state_d = IDLE;
               else state_d = DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle_o = (state_q == IDLE) && (cnt_q == '0);

`ifdef FP_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_q [N_REQ];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_REQ; k++) gcnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (gnt_s[k] && (gcnt_q[k] != '1)) gcnt_q[k] <= gcnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < N_REQ; k++) grant_cnt_o[k*CNT_W +: CNT_W] = gcnt_q[k];
  end
`endif

endmodule
